// File: rtl/tone_i2s_player.sv
// tone_i2s_player: per-channel square-wave tone synth, volume-scaled, serialised to a Pmod I2S DAC.
module tone_i2s_player #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned SIL_THRESH = 20_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] toneL,
  input  logic [31:0] toneR,
  input  logic [2:0]  vol,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic        audio_sdin,
  output logic        frame_tick
);
  localparam logic [32:0] CF = 33'(CLK_FREQ);
  logic [8:0]        r_cnt;
  logic [1:0][31:0]  r_acc;
  logic [1:0]        r_wave;
  logic [1:0][15:0]  r_lat;
  logic              r_sdin;
  logic              r_tick;
  logic [1:0][31:0]  w_tone;
  logic [1:0][32:0]  w_sum;
  logic [1:0]        w_sil;
  logic [1:0]        w_roll;
  logic [1:0][31:0]  w_acc_nxt;
  logic [1:0]        w_wave_nxt;
  logic [1:0][15:0]  w_samp;
  logic [1:0][15:0]  w_lat_nxt;
  logic [15:0]       w_amp;
  logic [8:0]        w_cnt_nxt;
  logic              w_wrap;
  logic              w_sdin_nxt;
  assign w_tone     = {toneR, toneL};
  assign w_amp      = {2'b00, vol, 11'd0};
  assign w_wrap     = &r_cnt;
  assign w_cnt_nxt  = r_cnt + 9'd1;
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_sil[k]      = (w_tone[k] == 32'd0) || (w_tone[k] >= SIL_THRESH);
      w_sum[k]      = {1'b0, r_acc[k]} + {w_tone[k], 1'b0};
      w_roll[k]     = w_sum[k] >= CF;
      w_acc_nxt[k]  = w_sil[k] ? 32'd0 : w_roll[k] ? 32'(w_sum[k] - CF) : w_sum[k][31:0];
      w_wave_nxt[k] = !w_sil[k] && (r_wave[k] ^ w_roll[k]);
      w_samp[k]     = (w_sil[k] || vol == 3'd0 || !en) ? 16'd0 : r_wave[k] ? w_amp : -w_amp;
      w_lat_nxt[k]  = w_wrap ? w_samp[k] : r_lat[k];
    end
  end
  // Look ahead one cycle so the registered data bit lines up with the falling sck edge.
  assign w_sdin_nxt = w_lat_nxt[w_cnt_nxt[8]][~w_cnt_nxt[7:4]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_wave <= '0;
      r_lat  <= '0;
      r_sdin <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_acc  <= w_acc_nxt;
      r_wave <= w_wave_nxt;
      r_lat  <= w_lat_nxt;
      r_sdin <= w_sdin_nxt;
      r_tick <= w_wrap;
    end
  assign audio_mclk = r_cnt[1];
  assign audio_sck  = r_cnt[3];
  assign audio_lrck = r_cnt[8];
  assign audio_sdin = r_sdin;
  assign frame_tick = r_tick;
endmodule

// File: tb/tb_tone_i2s_player.sv
// tb_tone_i2s_player: scoreboard bench; a reference model pushes expected frame words, a deserialiser pops and compares.
// CLK_FREQ is reduced so tone half-periods (1e6/880 = 1136.36 clk for 440 Hz) fit in a short run.
module tb_tone_i2s_player;
  localparam int unsigned CF = 1_000_000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] toneL = 32'd0;
  logic [31:0] toneR = 32'd0;
  logic [2:0]  vol = 3'd0;
  logic        audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_tick;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [8:0]  m_cnt = 9'd0;
  logic [31:0] m_acc_l = 32'd0;
  logic [31:0] m_acc_r = 32'd0;
  logic        m_wl = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [15:0] sh_l = 16'd0;
  logic [15:0] sh_r = 16'd0;
  logic [15:0] last_l = 16'd0;
  logic [15:0] last_r = 16'd0;
  logic [1:0]  bad = 2'd0;

  tone_i2s_player #(.CLK_FREQ(CF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .toneL(toneL), .toneR(toneR), .vol(vol),
    .audio_mclk(audio_mclk), .audio_sck(audio_sck), .audio_lrck(audio_lrck),
    .audio_sdin(audio_sdin), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] samp(input logic [31:0] t, input logic w);
    int a;
    a = int'(vol) * 2048;
    if (!en || vol == 3'd0 || t == 32'd0 || t >= 32'd20000) return 16'd0;
    return w ? 16'(a) : 16'(-a);
  endfunction

  function automatic void adv(input logic [31:0] t, inout logic [31:0] acc, inout logic w);
    longint s;
    if (t == 32'd0 || t >= 32'd20000) begin
      acc = 32'd0;
      w = 1'b0;
    end else begin
      s = longint'(acc) + 2 * longint'(t);
      if (s >= longint'(CF)) begin
        s = s - longint'(CF);
        w = ~w;
      end
      acc = 32'(s);
    end
  endfunction

  // Model advances on each edge; outputs are sampled 1 time unit later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 9'd0;
      m_acc_l = 32'd0;
      m_acc_r = 32'd0;
      m_wl = 1'b0;
      m_wr = 1'b0;
      bad = 2'd0;
      exp_q.delete();
      exp_q.push_back(32'd0);
    end else begin
      if (m_cnt == 9'd511) exp_q.push_back({samp(toneL, m_wl), samp(toneR, m_wr)});
      adv(toneL, m_acc_l, m_wl);
      adv(toneR, m_acc_r, m_wr);
      m_cnt = m_cnt + 9'd1;
      #1;
      if ({audio_mclk, audio_sck, audio_lrck} != {m_cnt[1], m_cnt[3], m_cnt[8]}) bad[0] = 1'b1;
      if (frame_tick != (m_cnt == 9'd0)) bad[1] = 1'b1;
      if (m_cnt[3:0] == 4'd8) begin
        if (m_cnt[8]) sh_r = {sh_r[14:0], audio_sdin};
        else sh_l = {sh_l[14:0], audio_sdin};
      end
      if (m_cnt == 9'd511) begin
        if (exp_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("word_l", 32'(sh_l), 32'(e[31:16]));
          chk("word_r", 32'(sh_r), 32'(e[15:0]));
        end
        chk("clk_tick", 32'(bad), 32'd0);
        bad = 2'd0;
        last_l = sh_l;
        last_r = sh_r;
      end
    end
  end

  task automatic wait_cnt(input logic [8:0] v);
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (m_cnt == v) return;
    end
    chk("wait_cnt", 32'(m_cnt), 32'(v));
  endtask

  initial begin
    int n;
    int ntog;
    logic prev;
    logic sd_or;
    repeat (10) @(posedge clk);
    #1 chk("rst_out", 32'({audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_tick}), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1 n++;
      if (frame_tick) break;
    end
    chk("tick_first", n, 32'd512);

    toneL = 32'd100_000_000;
    toneR = 32'd100_000_000;
    vol = 3'd5;
    en = 1'b1;
    wait_cnt(9'd511);
    sd_or = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      sd_or = sd_or | audio_sdin;
    end
    chk("silence", 32'(sd_or), 32'd0);

    toneL = 32'd440;
    toneR = 32'd0;
    vol = 3'd4;
    prev = dut.r_wave[0];
    ntog = 0;
    n = 0;
    for (int i = 0; i < 8000 && ntog < 5; i++) begin
      @(posedge clk);
      #1 n++;
      if (dut.r_wave[0] != prev) begin
        prev = dut.r_wave[0];
        if (ntog > 0) chk("half_per", 32'(n == 1136 || n == 1137), 32'd1);
        ntog++;
        n = 0;
      end
    end
    chk("toggles", ntog, 32'd5);
    wait_cnt(9'd511);
    wait_cnt(9'd511);
    chk("a4_l", 32'(last_l == 16'h2000 || last_l == 16'hE000), 32'd1);
    chk("a4_r", 32'(last_r), 32'd0);

    toneL = 32'd262;
    vol = 3'd0;
    wait_cnt(9'd511);
    wait_cnt(9'd511);
    chk("vol0", 32'(last_l), 32'd0);
    vol = 3'd7;
    en = 1'b0;
    wait_cnt(9'd511);
    wait_cnt(9'd511);
    chk("en0", 32'(last_l), 32'd0);
    wait_cnt(9'd100);
    en = 1'b1;
    wait_cnt(9'd511);
    chk("en_cur", 32'(last_l), 32'd0);
    wait_cnt(9'd511);
    chk("en_next", 32'(last_l == 16'h3800 || last_l == 16'hC800), 32'd1);

    wait_cnt(9'd100);
    toneL = 32'd0;
    wait_cnt(9'd511);
    chk("mid_cur", 32'(last_l == 16'h3800 || last_l == 16'hC800), 32'd1);
    wait_cnt(9'd511);
    chk("mid_next", 32'(last_l), 32'd0);

    toneL = 32'd262;
    toneR = 32'd19_999;
    wait_cnt(9'd511);
    wait_cnt(9'd511);
    chk("thr_m1_r", 32'(last_r == 16'h3800 || last_r == 16'hC800), 32'd1);
    toneR = 32'd20_000;
    wait_cnt(9'd511);
    wait_cnt(9'd511);
    chk("thr_r", 32'(last_r), 32'd0);

    wait_cnt(9'd300);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'({audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_tick}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_cnt(9'd511);
    chk("rst_word", 32'(last_l), 32'd0);
    wait_cnt(9'd511);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_i2s_player.md
# tone_i2s_player

Consumer end of the tone interface: takes the per-channel tone frequencies (`toneL`/`toneR`, Hz, 32-bit) produced by the step-sequencer/music blocks. Synthesises a square wave per channel, scales it by a volume setting and serialises both channels as 16-bit two's-complement samples to the Pmod I2S DAC. Sits between the music/sequencer block and the board audio pins.

## Interface

**Parameters**
- `CLK_FREQ`, default 100_000_000: system clock in Hz.
- `SIL_THRESH`, default 20_000: any tone ≥ this (including the 100_000_000 silence code), or tone == 0, is silent.

**Ports**
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: 0 forces both channel samples to 0. Clocks keep running.
- `toneL` in 32: left frequency, Hz.
- `toneR` in 32: right frequency, Hz.
- `vol` in 3: volume 0..7. 0 means mute.
- `audio_mclk` out 1: master clock, `CLK_FREQ`/4.
- `audio_sck` out 1: serial bit clock, `CLK_FREQ`/16.
- `audio_lrck` out 1: word select, `CLK_FREQ`/512. 0 selects left, 1 selects right.
- `audio_sdin` out 1: serial data, MSB first.
- `frame_tick` out 1: one-cycle pulse on the cycle the frame counter wraps.

## Operation

**Frame counter**
- 9-bit `cnt`, increments every clk, wraps 511→0.
- `audio_mclk` = `cnt[1]`, `audio_sck` = `cnt[3]`, `audio_lrck` = `cnt[8]`, all taken directly from register bits (glitch-free).

**Tone synthesis**, independent per channel, 32-bit phase accumulator `acc` plus a `wave` bit:
- Step = `tone`·2, in 33-bit arithmetic.
- If `acc` + step ≥ `CLK_FREQ`: `acc` ← `acc` + step − `CLK_FREQ` and `wave` toggles.
- Otherwise `acc` ← `acc` + step.
- Result: average half-period = `CLK_FREQ`/(2·tone) clk. Each interval is floor or ceil of that value.
- While the channel is silent, `acc` is held at 0 and `wave` at 0.
- On leaving silence, synthesis starts from `acc` = 0 with `wave` = 0.
- A tone change between audible values does not clear `acc`, so the phase stays continuous.

**Sample formation**, combinational from `wave`:
- `amp` = {`vol`, 11'b0}, so vol 7 gives 14336 (16'h3800).
- Sample = `wave` ? +`amp` : −`amp`, as 16-bit two's complement.
- Sample = 0 when silent, `vol` == 0, or `en` == 0.

**Latching**
- On the edge where `cnt` goes 511→0, both samples are captured into `latL`/`latR`.
- Samples are constant for the whole 512-clk frame. Tone, vol or en changes take effect in the next frame only.

**Serialisation**
- Bit index = 15 − `cnt[7:4]`.
- `audio_sdin` = (`cnt[8]` ? `latR` : `latL`)[index].
- `audio_sdin` is registered, computed from next-cycle `cnt` and latch values. It therefore changes only on the clk where `audio_sck` falls (`cnt[3:0]` 15→0).
- Exception: on the wrap edge it takes bit 15 of the newly latched left sample.

## Timing

**Reset** (`rst_n` low, asynchronous): `cnt`, `acc` (both), `wave` (both), `latL`, `latR`, `audio_sdin` and `frame_tick` all go to 0. Therefore `audio_mclk`, `audio_sck` and `audio_lrck` are all 0.

**After `rst_n` release**
- First clk edge: `cnt` = 1.
- `audio_mclk` rises at `cnt` = 2.
- `audio_sck` rises at `cnt` = 8.
- `audio_lrck` rises at `cnt` = 256.

**`frame_tick`**: high for exactly the one clk with `cnt` = 0 after a wrap. It is not asserted on the first frame after reset.

**Latency**: input change to first affected serial bit is at most 512 + 1 clk.

**Reset mid-frame**: the partial frame is discarded. After release, the frame restarts from `cnt` = 0 with the latches at 0.

**Boundaries**
- tone == `SIL_THRESH` − 1 is audible.
- tone == `SIL_THRESH` is silent.
- The 33-bit sum never overflows for tone < `SIL_THRESH`.

## Test plan

1. **Reset and clocks.** Stimulus: hold `rst_n` = 0 for 10 clk, then release. Required: all outputs 0 during reset; after release `audio_mclk` period is 4 clk, `audio_sck` 16 clk, `audio_lrck` 512 clk; `frame_tick` pulses every 512 clk starting at clk 512.
2. **Silence code.** Stimulus: `toneL` = `toneR` = 100_000_000, `vol` = 5, `en` = 1. Required: `audio_sdin` stays 0 for 4 frames.
3. **A4 left, silent right.** Stimulus: `toneL` = 440, `toneR` = 0, `vol` = 4. Required:
   - `wave` toggle intervals are 113636 or 113637 clk.
   - Deserialised left words are only 16'h2000 or 16'hE000.
   - Right words are 16'h0000.
4. **Mute paths.** Stimulus: `toneL` = 262 with `vol` = 0, then `vol` = 7 with `en` = 0. Required: all words 0. Then `en` = 1: words are 16'h3800/16'hC800 starting from the next frame.
5. **Mid-frame change.** Stimulus: at `cnt` = 100, change `toneL` from 262 to 0. Required: the current frame's left word is unchanged; the next frame's left word is 0.
6. **Asynchronous reset mid-frame.** Stimulus: pulse `rst_n` low for 3 clk at `cnt` = 300, asserted between clock edges. Required: outputs go to 0 immediately, without waiting for a clk edge; the following frame restarts at `cnt` = 0 and its first word is 0.
